// File: rtl/pipe_control.sv
// pipe_control: ID-stage opcode decode plus ID/EX, EX/MEM and MEM/WB control
// registers, with hazard detection, bubble insertion and branch flush.
// Optional feature: define FORWARD_EN to enable the forwarding unit, so that
// only load-use hazards stall. Without it, fwd_a/fwd_b stay 00 and any pending
// ID/EX or EX/MEM producer of a used source stalls until it reaches WB.
module pipe_control #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [10:0]      id_opcode,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mem_pc_src,
  output logic             id_reg2loc,
  output logic [2:0]       id_signop,
  output logic             ex_alusrc,
  output logic [3:0]       ex_aluop,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic             mem_uncond_branch,
  output logic             wb_regwrite,
  output logic             wb_mem2reg,
  output logic [REG_W-1:0] wb_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state;

  // decoded ID bundle
  logic       d_known, d_regwrite, d_mem2reg, d_memread, d_memwrite;
  logic       d_branch, d_uncond, d_alusrc, d_use1, d_use2;
  logic [3:0] d_aluop;
  logic       d_valid;
  logic [REG_W-1:0] d_src2;

  // ID/EX internal fields
  logic ex_regwrite, ex_mem2reg, ex_memread, ex_memwrite, ex_branch, ex_uncond;
  logic [REG_W-1:0] ex_rd;
  // EX/MEM internal fields
  logic mem_regwrite, mem_mem2reg;
  logic [REG_W-1:0] mem_rd;

  logic running, flush, stall, ex_hit;

  // Opcode decode; anything unmatched leaves every flag at zero
  always_comb begin
    d_known    = 1'b1;
    d_regwrite = 1'b0;
    d_mem2reg  = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_branch   = 1'b0;
    d_uncond   = 1'b0;
    d_alusrc   = 1'b0;
    d_use1     = 1'b0;
    d_use2     = 1'b0;
    d_aluop    = 4'b0000;
    id_signop  = 3'b000;
    id_reg2loc = 1'b0;
    casez (id_opcode)
      11'b111_1100_0010: begin // LDUR
        d_aluop = 4'b0010; id_signop = 3'b001;
        d_memread = 1'b1; d_mem2reg = 1'b1; d_regwrite = 1'b1; d_use1 = 1'b1;
      end
      11'b111_1100_0000: begin // STUR
        d_aluop = 4'b0010; id_signop = 3'b001; id_reg2loc = 1'b1;
        d_memwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b100_0101_1000: begin // ADD
        d_aluop = 4'b0010; d_regwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b110_0101_1000: begin // SUB
        d_aluop = 4'b0110; d_regwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b100_0101_0000: begin // AND
        d_aluop = 4'b0000; d_regwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b101_0101_0000: begin // ORR
        d_aluop = 4'b0001; d_regwrite = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b100_1000_100?: begin // ADDI
        d_aluop = 4'b0010; d_alusrc = 1'b1; d_regwrite = 1'b1; d_use1 = 1'b1;
      end
      11'b110_1000_100?: begin // SUBI
        d_aluop = 4'b0110; d_alusrc = 1'b1; d_regwrite = 1'b1; d_use1 = 1'b1;
      end
      11'b110_1001_01??: begin // MOVZ
        d_aluop = 4'b0111; d_alusrc = 1'b1; d_regwrite = 1'b1;
        id_signop = {1'b1, id_opcode[1:0]};
      end
      11'b101_1010_0???: begin // CBZ
        d_aluop = 4'b0111; id_reg2loc = 1'b1; d_branch = 1'b1; id_signop = 3'b010;
        d_use1 = 1'b1; d_use2 = 1'b1;
      end
      11'b000_101?_????: begin // B
        d_uncond = 1'b1; id_signop = 3'b011;
      end
      default: d_known = 1'b0;
    endcase
  end

  assign d_valid = id_valid & d_known;
  assign d_src2  = id_reg2loc ? id_rt : id_rm;
  assign running = (state == ST_RUN);
  assign flush   = mem_pc_src;

  assign ex_hit = id_valid && (ex_rd != XZR) &&
                  ((d_use1 && ex_rd == id_rn) || (d_use2 && ex_rd == d_src2));

`ifdef FORWARD_EN
  logic [REG_W-1:0] ex_src1, ex_src2;

  assign stall = ex_memread & ex_hit;

  // Operand source select; EX/MEM result is newer so it wins over MEM/WB
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (mem_regwrite && mem_rd != XZR && mem_rd == ex_src1)     fwd_a = 2'b10;
    else if (wb_regwrite && wb_rd != XZR && wb_rd == ex_src1)   fwd_a = 2'b01;
    if (mem_regwrite && mem_rd != XZR && mem_rd == ex_src2)     fwd_b = 2'b10;
    else if (wb_regwrite && wb_rd != XZR && wb_rd == ex_src2)   fwd_b = 2'b01;
  end
`else
  logic mem_hit;

  assign mem_hit = id_valid && (mem_rd != XZR) &&
                   ((d_use1 && mem_rd == id_rn) || (d_use2 && mem_rd == d_src2));
  assign stall = (ex_regwrite & ex_hit) | (mem_regwrite & mem_hit);
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  // Flush beats stall; nothing advances until the first post-reset edge
  assign pc_write   = running & (flush | ~stall);
  assign ifid_write = pc_write;
  assign ifid_flush = ~running | flush;

  // Pipeline control registers; bubbles are injected at ID/EX and EX/MEM
  always_ff @(posedge CLK) begin
    if (reset) begin
      state             <= ST_INIT;
      ex_regwrite       <= 1'b0;
      ex_mem2reg        <= 1'b0;
      ex_memread        <= 1'b0;
      ex_memwrite       <= 1'b0;
      ex_branch         <= 1'b0;
      ex_uncond         <= 1'b0;
      ex_alusrc         <= 1'b0;
      ex_aluop          <= '0;
      ex_rd             <= '0;
      mem_regwrite      <= 1'b0;
      mem_mem2reg       <= 1'b0;
      mem_memread       <= 1'b0;
      mem_memwrite      <= 1'b0;
      mem_branch        <= 1'b0;
      mem_uncond_branch <= 1'b0;
      mem_rd            <= '0;
      wb_regwrite       <= 1'b0;
      wb_mem2reg        <= 1'b0;
      wb_rd             <= '0;
`ifdef FORWARD_EN
      ex_src1           <= XZR;
      ex_src2           <= XZR;
`endif
    end else begin
      state <= ST_RUN;
      if (flush || stall || !running || !d_valid) begin
        ex_regwrite <= 1'b0;
        ex_mem2reg  <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_branch   <= 1'b0;
        ex_uncond   <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_aluop    <= '0;
        ex_rd       <= '0;
`ifdef FORWARD_EN
        ex_src1     <= XZR;
        ex_src2     <= XZR;
`endif
      end else begin
        ex_regwrite <= d_regwrite;
        ex_mem2reg  <= d_mem2reg;
        ex_memread  <= d_memread;
        ex_memwrite <= d_memwrite;
        ex_branch   <= d_branch;
        ex_uncond   <= d_uncond;
        ex_alusrc   <= d_alusrc;
        ex_aluop    <= d_aluop;
        ex_rd       <= id_rt;
`ifdef FORWARD_EN
        ex_src1     <= d_use1 ? id_rn : XZR;
        ex_src2     <= d_use2 ? d_src2 : XZR;
`endif
      end
      if (flush) begin
        mem_regwrite      <= 1'b0;
        mem_mem2reg       <= 1'b0;
        mem_memread       <= 1'b0;
        mem_memwrite      <= 1'b0;
        mem_branch        <= 1'b0;
        mem_uncond_branch <= 1'b0;
        mem_rd            <= '0;
      end else begin
        mem_regwrite      <= ex_regwrite;
        mem_mem2reg       <= ex_mem2reg;
        mem_memread       <= ex_memread;
        mem_memwrite      <= ex_memwrite;
        mem_branch        <= ex_branch;
        mem_uncond_branch <= ex_uncond;
        mem_rd            <= ex_rd;
      end
      wb_regwrite <= mem_regwrite;
      wb_mem2reg  <= mem_mem2reg;
      wb_rd       <= mem_rd;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed hazard scenarios plus random instruction streams,
// checked each cycle against a table-driven instruction-level pipeline model.
module tb_pipe_control;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ZERO_REG = 31;

  logic             CLK = 1'b0;
  logic             reset, id_valid, mem_pc_src;
  logic [10:0]      id_opcode;
  logic [REG_W-1:0] id_rn, id_rm, id_rt;
  logic             id_reg2loc, ex_alusrc;
  logic [2:0]       id_signop;
  logic [3:0]       ex_aluop;
  logic             mem_memread, mem_memwrite, mem_branch, mem_uncond_branch;
  logic             wb_regwrite, wb_mem2reg;
  logic [REG_W-1:0] wb_rd;
  logic             pc_write, ifid_write, ifid_flush;
  logic [1:0]       fwd_a, fwd_b;

  always #5 CLK = ~CLK;

  pipe_control #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) dut (
    .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .mem_pc_src(mem_pc_src),
    .id_reg2loc(id_reg2loc), .id_signop(id_signop),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_branch(mem_branch), .mem_uncond_branch(mem_uncond_branch),
    .wb_regwrite(wb_regwrite), .wb_mem2reg(wb_mem2reg), .wb_rd(wb_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct packed {
    logic v; logic [10:0] op; logic [4:0] rn, rm, rt;
  } instr_t;

  // flags order: rw m2r mr mw br ub as ; extra order: r2l u1 u2 hw
  typedef struct packed {
    logic [10:0] mask, val;
    logic rw, m2r, mr, mw, br, ub, as;
    logic [3:0] aluop; logic [2:0] sop;
    logic r2l, u1, u2, hw;
  } row_t;

  typedef struct packed {
    logic ok, rw, m2r, mr, mw, br, ub, as;
    logic [3:0] aluop; logic [2:0] sop;
    logic r2l, u1, u2;
    logic [4:0] s1, s2, rd;
  } rec_t;

  row_t   tbl [11];
  rec_t   pipe [3];     // 0 = EX, 1 = MEM, 2 = WB
  logic   running;
  logic   take_br;
  instr_t prog [$];
  int     vecs = 0;
  int     errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t decode(input instr_t i);
    rec_t r = '0;
    for (int k = 0; k < 11; k++) begin
      if (!r.ok && ((i.op & tbl[k].mask) == tbl[k].val)) begin
        r.ok = 1'b1; r.rw = tbl[k].rw; r.m2r = tbl[k].m2r; r.mr = tbl[k].mr;
        r.mw = tbl[k].mw; r.br = tbl[k].br; r.ub = tbl[k].ub; r.as = tbl[k].as;
        r.aluop = tbl[k].aluop; r.r2l = tbl[k].r2l; r.u1 = tbl[k].u1; r.u2 = tbl[k].u2;
        r.sop = tbl[k].hw ? {1'b1, i.op[1:0]} : tbl[k].sop;
      end
    end
    r.s1 = i.rn;
    r.s2 = r.r2l ? i.rt : i.rm;
    r.rd = i.rt;
    return r;
  endfunction

  function automatic logic reads(input rec_t c, input logic [4:0] r);
    return (r != 5'(ZERO_REG)) && ((c.u1 && c.s1 == r) || (c.u2 && c.s2 == r));
  endfunction

`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_of(input logic u, input logic [4:0] s);
    if (!u) return 2'b00;
    if (pipe[1].rw && pipe[1].rd != 5'(ZERO_REG) && pipe[1].rd == s) return 2'b10;
    if (pipe[2].rw && pipe[2].rd != 5'(ZERO_REG) && pipe[2].rd == s) return 2'b01;
    return 2'b00;
  endfunction
`endif

  function automatic instr_t mk(input logic [10:0] op, input logic [4:0] rn, rm, rt);
    return {1'b1, op, rn, rm, rt};
  endfunction

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    int unsigned k = $urandom_range(0, 11);
    logic [10:0] noise = 11'($urandom);
    i.v  = ($urandom_range(0, 7) != 0);
    i.op = (k == 11) ? noise : (tbl[k].val | (noise & ~tbl[k].mask));
    i.rn = rnd_reg(); i.rm = rnd_reg(); i.rt = rnd_reg();
    return i;
  endfunction

  // One clock: drive ID from the program head, check all outputs, advance model
  task automatic cycle(input logic rst, input logic pcsrc);
    instr_t cur = (prog.size() > 0) ? prog[0] : '0;
    rec_t dec = decode(cur);
    rec_t ent = (cur.v && dec.ok) ? dec : '0;
    logic stall, pcw, fl;
    logic [1:0] fa, fb;
    reset = rst; id_valid = cur.v; id_opcode = cur.op;
    id_rn = cur.rn; id_rm = cur.rm; id_rt = cur.rt; mem_pc_src = pcsrc;
    @(negedge CLK);
`ifdef FORWARD_EN
    stall = pipe[0].mr && reads(ent, pipe[0].rd);
    fa = fwd_of(pipe[0].u1, pipe[0].s1);
    fb = fwd_of(pipe[0].u2, pipe[0].s2);
`else
    stall = (pipe[0].rw && reads(ent, pipe[0].rd)) || (pipe[1].rw && reads(ent, pipe[1].rd));
    fa = 2'b00;
    fb = 2'b00;
`endif
    pcw = running && (pcsrc || !stall);
    fl  = !running || pcsrc;
    check("id_reg2loc", 32'(id_reg2loc), 32'(dec.r2l));
    check("id_signop", 32'(id_signop), 32'(dec.sop));
    check("ex_alusrc", 32'(ex_alusrc), 32'(pipe[0].as));
    check("ex_aluop", 32'(ex_aluop), 32'(pipe[0].aluop));
    check("mem_memread", 32'(mem_memread), 32'(pipe[1].mr));
    check("mem_memwrite", 32'(mem_memwrite), 32'(pipe[1].mw));
    check("mem_branch", 32'(mem_branch), 32'(pipe[1].br));
    check("mem_uncond", 32'(mem_uncond_branch), 32'(pipe[1].ub));
    check("wb_regwrite", 32'(wb_regwrite), 32'(pipe[2].rw));
    check("wb_mem2reg", 32'(wb_mem2reg), 32'(pipe[2].m2r));
    check("wb_rd", 32'(wb_rd), 32'(pipe[2].rd));
    check("pc_write", 32'(pc_write), 32'(pcw));
    check("ifid_write", 32'(ifid_write), 32'(pcw));
    check("ifid_flush", 32'(ifid_flush), 32'(fl));
    check("fwd_a", 32'(fwd_a), 32'(fa));
    check("fwd_b", 32'(fwd_b), 32'(fb));
    if (rst) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      running = 1'b0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pcsrc ? '0 : pipe[0];
      pipe[0] = (pcsrc || stall || !running) ? '0 : ent;
      running = 1'b1;
      if (pcw && prog.size() > 0) void'(prog.pop_front());
      if (pcsrc) prog.push_front('0);
    end
    @(posedge CLK);
    #1;
  endtask

  // Run the queued program to completion, then let the pipe drain
  task automatic run_prog();
    for (int n = 0; n < 64 && prog.size() > 0; n++)
      cycle(1'b0, take_br & pipe[1].br);
    check("prog_drained", 32'(prog.size()), 32'd0);
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = {11'h7FF, 11'h7C2, 7'b1110000, 4'h2, 3'd1, 4'b0100}; // LDUR
    tbl[1]  = {11'h7FF, 11'h7C0, 7'b0001000, 4'h2, 3'd1, 4'b1110}; // STUR
    tbl[2]  = {11'h7FF, 11'h458, 7'b1000000, 4'h2, 3'd0, 4'b0110}; // ADD
    tbl[3]  = {11'h7FF, 11'h658, 7'b1000000, 4'h6, 3'd0, 4'b0110}; // SUB
    tbl[4]  = {11'h7FF, 11'h450, 7'b1000000, 4'h0, 3'd0, 4'b0110}; // AND
    tbl[5]  = {11'h7FF, 11'h550, 7'b1000000, 4'h1, 3'd0, 4'b0110}; // ORR
    tbl[6]  = {11'h7FE, 11'h488, 7'b1000001, 4'h2, 3'd0, 4'b0100}; // ADDI
    tbl[7]  = {11'h7FE, 11'h688, 7'b1000001, 4'h6, 3'd0, 4'b0100}; // SUBI
    tbl[8]  = {11'h7FC, 11'h694, 7'b1000001, 4'h7, 3'd4, 4'b0001}; // MOVZ
    tbl[9]  = {11'h7F8, 11'h5A0, 7'b0000100, 4'h7, 3'd2, 4'b1110}; // CBZ
    tbl[10] = {11'h7E0, 11'h0A0, 7'b0000010, 4'h0, 3'd3, 4'b0000}; // B
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    running = 1'b0;
    take_br = 1'b1;
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0;
    id_rn = '0; id_rm = '0; id_rt = '0; mem_pc_src = 1'b0;
    @(posedge CLK);
    #1;

    // reset held two cycles, then released
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // LDUR X1,[X5] ; ADD X2,X1,X3
    prog.push_back(mk(11'h7C2, 5'd5, 5'd0, 5'd1));
    prog.push_back(mk(11'h458, 5'd1, 5'd3, 5'd2));
    run_prog();

    // ADD X1,X2,X3 ; SUB X4,X1,X1
    prog.push_back(mk(11'h458, 5'd2, 5'd3, 5'd1));
    prog.push_back(mk(11'h658, 5'd1, 5'd1, 5'd4));
    run_prog();

    // CBZ X9 reaches MEM (taken) while LDUR X1 / ADD X2,X1,X3 load-use is pending
    prog.push_back(mk(11'h5A0, 5'd9, 5'd0, 5'd9));
    prog.push_back(mk(11'h7C2, 5'd5, 5'd0, 5'd1));
    prog.push_back(mk(11'h458, 5'd1, 5'd3, 5'd2));
    prog.push_back(mk(11'h450, 5'd6, 5'd7, 5'd8));
    run_prog();

    // LDUR X31 ; ADD X2,X31,X31
    prog.push_back(mk(11'h7C2, 5'd5, 5'd0, 5'd31));
    prog.push_back(mk(11'h458, 5'd31, 5'd31, 5'd2));
    run_prog();

    // MOVZ hw=10 ; unknown opcode 0x000 carried through to WB
    prog.push_back(mk(11'h696, 5'd0, 5'd0, 5'd7));
    prog.push_back(mk(11'h000, 5'd1, 5'd2, 5'd3));
    run_prog();

    // random streams with random flushes and occasional mid-flight reset
    for (int n = 0; n < 600; n++) begin
      if (prog.size() < 3) prog.push_back(rnd_instr());
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined successor to the single-cycle ARMv8 control decoder. It decodes the 11-bit opcode in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and RAW hazards, inserts bubbles, and flushes the wrong path after a taken branch. It sits between the IF/ID register and the five-stage datapath.

## Interface
- REG_W, 5, register-specifier width
- ZERO_REG, 31, index of XZR; never a hazard source or destination
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  11  instr[31:21]
- id_rn, id_rm, id_rt  in  REG_W each  instr[9:5], instr[20:16], instr[4:0]
- mem_pc_src  in  1  branch taken, resolved in MEM
- id_reg2loc  out  1  combinational from id_opcode
- id_signop  out  3  combinational from id_opcode
- ex_alusrc  out  1  EX-stage control
- ex_aluop  out  4  EX-stage control
- mem_memread, mem_memwrite, mem_branch, mem_uncond_branch  out  1 each  MEM-stage control
- wb_regwrite, wb_mem2reg  out  1 each  WB-stage control
- wb_rd  out  REG_W  WB destination register
- pc_write, ifid_write  out  1 each  low = hold
- ifid_flush  out  1  clear IF/ID on next edge
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB

## Operation
- Decode, with aluop / signop / write and memory flags:
  - LDUR 0x7C2: aluop 0010, signop 001, memread, mem2reg, regwrite.
  - STUR 0x7C0: aluop 0010, signop 001, reg2loc=1, memwrite.
  - ADD 0x458: aluop 0010, regwrite.
  - SUB 0x658: aluop 0110, regwrite.
  - AND 0x450: aluop 0000, regwrite.
  - ORR 0x550: aluop 0001, regwrite.
  - ADDI 1001000100x: aluop 0010, alusrc, signop 000, regwrite.
  - SUBI 1101000100x: aluop 0110, alusrc, signop 000, regwrite.
  - MOVZ 110100101hw: aluop 0111, alusrc, signop {1,hw}, regwrite.
  - CBZ 10110100xxx: aluop 0111, reg2loc=1, branch, signop 010.
  - B 000101xxxxx: uncond_branch, signop 011.
- Unknown opcode or id_valid=0: bubble. Bubble = all write, memory and branch flags 0, aluop 0000, signop 000.
- Sources:
  - src1 = rn for all except B and MOVZ.
  - src2 = rm when reg2loc=0 and R-type; rt for STUR and CBZ.
- Load-use hazard: ID/EX is LDUR, its rd ≠ ZERO_REG, and rd equals a used ID source.
  - Drive pc_write=0 and ifid_write=0.
  - Load a bubble into ID/EX.
- Flush: mem_pc_src=1.
  - Drive ifid_flush=1.
  - Load bubbles into ID/EX and EX/MEM next edge.
  - Flush overrides stall; pc_write=1.
- Forwarding (macro on):
  - fwd_x=10 if EX/MEM regwrite, rd ≠ ZERO_REG, and rd matches the EX source.
  - Otherwise fwd_x=01 on a MEM/WB match.
  - EX/MEM has priority over MEM/WB.

## Timing
- Reset values: all stage control outputs 0 (bubble), wb_rd=0, fwd_a=fwd_b=00, pc_write=0, ifid_write=0, ifid_flush=1.
- First edge after reset deasserts: pc_write=1, ifid_write=1, ifid_flush=0.
- Control latency: ID→EX 1 cycle, →MEM 2 cycles, →WB 3 cycles.
- Load-use stall lasts exactly 1 cycle; the consumer re-decodes next cycle and proceeds with fwd=01.
- Stall and flush in the same cycle: flush wins; no extra stall cycle.
- reset mid-stall or mid-flush: all pipeline control returns to bubble on that edge.
- The register file writes in the first half-cycle, so a WB-stage producer never causes a hazard.

## Configuration
- FORWARD_EN defined: forwarding unit active; only load-use stalls.
- FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Stall whenever ID/EX or EX/MEM has regwrite, rd ≠ ZERO_REG, and rd matches a used ID source.
  - Stall is held until the producer reaches WB, up to 2 cycles.

## Test plan
- Reset held 2 cycles, then released: outputs at reset values; pc_write=1 and ifid_flush=0 one cycle after release.
- LDUR X1 followed by ADD X2,X1,X3 (macro on): exactly 1 stall cycle, one bubble in EX, ADD in EX with fwd_a=01.
- ADD X1 followed by SUB X4,X1,X1 (macro on): no stall, fwd_a=fwd_b=10. Macro off: 2 stall cycles, fwd=00.
- CBZ taken (mem_pc_src=1) while a load-use stall is pending: ifid_flush=1, pc_write=1, next cycle ID/EX and EX/MEM are bubbles.
- LDUR X31 followed by ADD X2,X31,X31: no stall, no forwarding.
- MOVZ hw=10 followed by opcode 0x000: id_signop=110; the unknown opcode produces an all-zero bubble through to WB.
